// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and flag logic for the dual-clock FIFO: binary/Gray write
// pointers, read-pointer synchronizer, full / almost-full / level / overflow flags.
module fifo_wptr_full #(
    parameter int ASIZE        = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             winc,
    input  logic [ASIZE:0]   rgray,
    input  logic             wclr_ovf,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wlevel,
    output logic             woverflow
);

    localparam logic [ASIZE:0] AFULL_LVL = (ASIZE+1)'(AFULL_THRESH);

    logic [ASIZE:0] wbin;
    logic [ASIZE:0] wbin_next;
    logic [ASIZE:0] wgray_next;
    logic [ASIZE:0] wq1_rptr;
    logic [ASIZE:0] wq2_rptr;
    logic [ASIZE:0] rbin_s;
    logic [ASIZE:0] wdiff;
    logic [ASIZE:0] full_ptr;
    logic           wen;

    always_comb begin
        wen        = winc & ~wfull;
        wbin_next  = wbin + {{ASIZE{1'b0}}, wen};
        wgray_next = (wbin_next >> 1) ^ wbin_next;
        // each binary bit is the XOR of all Gray bits at or above it
        for (int i = 0; i <= ASIZE; i++) begin
            rbin_s[i] = ^(wq2_rptr >> i);
        end
        wdiff    = wbin_next - rbin_s;
        full_ptr = {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};
    end

    assign waddr = wbin[ASIZE-1:0];

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wq1_rptr <= '0;
            wq2_rptr <= '0;
        end else begin
            wq1_rptr <= rgray;
            wq2_rptr <= wq1_rptr;
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= (wgray_next == full_ptr);
            walmost_full <= (wdiff >= AFULL_LVL);
            wlevel       <= wdiff;
        end
    end

    // set has priority over clear
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            woverflow <= 1'b0;
        end else if (winc & wfull) begin
            woverflow <= 1'b1;
        end else if (wclr_ovf) begin
            woverflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full: a count-based reference model pushes expected
// outputs per edge, a monitor pops and compares after each rising edge.
module tb_fifo_wptr_full;
    localparam int ASIZE = 4;
    localparam int TH    = 12;
    localparam int DEPTH = 1 << ASIZE;

    logic             wclk = 1'b0;
    logic             wrst;
    logic             winc;
    logic [ASIZE:0]   rgray;
    logic             wclr_ovf;
    logic [ASIZE-1:0] waddr;
    logic [ASIZE:0]   wptr;
    logic             wfull;
    logic             walmost_full;
    logic [ASIZE:0]   wlevel;
    logic             woverflow;

    fifo_wptr_full #(.ASIZE(ASIZE), .AFULL_THRESH(TH)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .rgray(rgray), .wclr_ovf(wclr_ovf),
        .waddr(waddr), .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
        .wlevel(wlevel), .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        int waddr;
        int wptr;
        int wfull;
        int walmost_full;
        int wlevel;
        int woverflow;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    // reference model state: counts are unbounded integers
    int   wcount;
    int   rd_cnt;
    int   rhist[$];
    int   whist[$];
    bit   m_full;
    bit   m_ovf;
    logic [ASIZE:0] prev_wptr = '0;

    function automatic logic [ASIZE:0] gray(input int v);
        logic [ASIZE:0] b;
        b = (ASIZE+1)'(v % (2*DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wcount = 0;
        rd_cnt = 0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        rhist  = '{0, 0};
        whist.delete();
    endtask

    // drive one cycle of stimulus and push the expected post-edge outputs
    task automatic step(input bit w, input bit c);
        exp_t e;
        int   rs;
        int   lvl;
        bit   acc;
        @(negedge wclk);
        winc     = w;
        wclr_ovf = c;
        rgray    = gray(rd_cnt);
        rhist.push_back(rd_cnt);
        if (rhist.size() > 3) void'(rhist.pop_front());
        rs  = rhist[0];
        acc = w && !m_full;
        if (w && m_full) m_ovf = 1'b1;
        else if (c)      m_ovf = 1'b0;
        wcount += int'(acc);
        lvl    = wcount - rs;
        m_full = (lvl == DEPTH);
        e.waddr        = wcount % DEPTH;
        e.wptr         = int'(gray(wcount));
        e.wfull        = int'(m_full);
        e.walmost_full = int'(lvl >= TH);
        e.wlevel       = lvl;
        e.woverflow    = int'(m_ovf);
        sb.push_back(e);
    endtask

    task automatic async_reset_check();
        @(posedge wclk);
        #3;
        wrst = 1'b1;
        #1;
        chk("rst_waddr", 32'(waddr), 0);
        chk("rst_wptr", 32'(wptr), 0);
        chk("rst_wfull", 32'(wfull), 0);
        chk("rst_walmost_full", 32'(walmost_full), 0);
        chk("rst_wlevel", 32'(wlevel), 0);
        chk("rst_woverflow", 32'(woverflow), 0);
        @(negedge wclk);
        @(negedge wclk);
        wrst     = 1'b0;
        winc     = 1'b0;
        wclr_ovf = 1'b0;
        rgray    = '0;
        model_reset();
    endtask

    initial begin : monitor
        forever begin
            @(posedge wclk);
            #1;
            if (!wrst && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("waddr", 32'(waddr), 32'(e.waddr));
                chk("wptr", 32'(wptr), 32'(e.wptr));
                chk("wfull", 32'(wfull), 32'(e.wfull));
                chk("walmost_full", 32'(walmost_full), 32'(e.walmost_full));
                chk("wlevel", 32'(wlevel), 32'(e.wlevel));
                chk("woverflow", 32'(woverflow), 32'(e.woverflow));
                chk("wptr_onebit", 32'($countones(wptr ^ prev_wptr) <= 1), 1);
            end
            prev_wptr = wptr;
        end
    end

    initial begin : stimulus
        wrst     = 1'b1;
        winc     = 1'b0;
        wclr_ovf = 1'b0;
        rgray    = '0;
        model_reset();
        #1;
        chk("init_wptr", 32'(wptr), 0);
        chk("init_wfull", 32'(wfull), 0);
        @(negedge wclk);
        @(negedge wclk);
        wrst = 1'b0;

        // fill to full with the reader idle
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0);
        @(posedge wclk);
        #1;
        chk("fill_wptr_gray16", 32'(wptr), 32'h18);
        chk("fill_wlevel16", 32'(wlevel), 16);

        // overflow: set, clear, then set-wins-over-clear
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // release from full through the synchronizer
        rd_cnt = 4;
        repeat (3) step(1'b0, 1'b0);
        rd_cnt = 5;
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);

        // async reset mid-fill at level 7
        async_reset_check();
        repeat (7) step(1'b1, 1'b0);
        async_reset_check();

        // wrap: reader trails the writer by 4 cycles
        for (int i = 0; i < 48; i++) begin
            whist.push_back(wcount);
            rd_cnt = (whist.size() > 4) ? whist[whist.size()-5] : 0;
            step(i < 40, 1'b0);
        end

        // random traffic with a legal, single-step reader
        for (int i = 0; i < 400; i++) begin
            if (rd_cnt < wcount && $urandom_range(9) < 4) rd_cnt++;
            step($urandom_range(9) < 7, $urandom_range(9) == 0);
        end

        step(1'b0, 1'b0);
        @(posedge wclk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
